// File: rtl/shape_scheduler.sv
// Round-robin scheduler that hands a single output channel to one of four
// shape generators at a time, with a blanking guard before each new grant.
module shape_scheduler #(
  parameter int DWELL_CYCLES = 50000,
  parameter int GUARD_CYCLES = 4
) (
  input  logic       sysclk,
  input  logic       Reset_N,
  input  logic [3:0] Enable_SW,
  input  logic [3:0] Pulse_In,
  output logic [3:0] Shape_En,
  output logic [1:0] Sel,
  output logic       Pulse_Out,
  output logic       Blank,
  output logic       Busy
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GUARD, RUN} state_t;

  state_t        state_q, state_d;
  logic [3:0]    sync1_q, sync2_q;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [3:0]    req;
  logic [3:0]    cand;
  logic          pick;
  logic          found;
  logic [1:0]    win;
  logic [1:0]    idx;

  assign req = sync2_q;

  always_ff @(posedge sysclk) begin
    if (!Reset_N) begin
      state_q <= IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= Enable_SW;
      sync2_q <= sync1_q;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Decide whether this cycle ends the current ownership, and which
  // requests are eligible; a dropped request excludes its own index.
  always_comb begin
    cand = req;
    pick = 1'b0;
    case (state_q)
      IDLE:  pick = 1'b1;
      GUARD: begin
        if (!req[sel_q]) begin
          pick        = 1'b1;
          cand[sel_q] = 1'b0;
        end
      end
      RUN: begin
        if (!req[sel_q]) begin
          pick        = 1'b1;
          cand[sel_q] = 1'b0;
        end else if (cnt_q == DWELL_LAST) begin
          pick = 1'b1;
        end
      end
      default: pick = 1'b1;
    endcase
  end

  // Search order last+1, last+2, last+3, last: the current owner wins only
  // if nobody else is asking.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (cand[idx] && !found) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (pick) begin
      cnt_d = '0;
      if (!found) begin
        state_d = IDLE;
      end else if (!(state_q == RUN && win == sel_q)) begin
        state_d = GUARD;
        sel_d   = win;
        last_d  = win;
      end
    end else if (state_q == GUARD && cnt_q == GUARD_LAST) begin
      state_d = RUN;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Enable is decoded from the registered grant, so it is one-hot by construction.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_en
      assign Shape_En[gi] = (state_q != IDLE) && (sel_q == 2'(gi));
    end
  endgenerate

  assign Sel       = sel_q;
  assign Blank     = (state_q == GUARD);
  assign Busy      = (state_q != IDLE);
  assign Pulse_Out = (state_q == RUN) && Pulse_In[sel_q];

endmodule

// File: tb/tb_shape_scheduler.sv
// Directed bench for shape_scheduler with a short dwell (8) and guard (2).
module tb_shape_scheduler;

  logic       sysclk = 1'b0;
  logic       Reset_N;
  logic [3:0] Enable_SW;
  logic [3:0] Pulse_In;
  logic [3:0] Shape_En;
  logic [1:0] Sel;
  logic       Pulse_Out;
  logic       Blank;
  logic       Busy;

  int tests_run = 0;
  int tests_failed = 0;

  shape_scheduler #(.DWELL_CYCLES(8), .GUARD_CYCLES(2)) dut (
    .sysclk   (sysclk),
    .Reset_N  (Reset_N),
    .Enable_SW(Enable_SW),
    .Pulse_In (Pulse_In),
    .Shape_En (Shape_En),
    .Sel      (Sel),
    .Pulse_Out(Pulse_Out),
    .Blank    (Blank),
    .Busy     (Busy)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One rising edge, then settle to the falling edge for sampling/driving.
  task automatic step();
    @(posedge sysclk);
    @(negedge sysclk);
  endtask

  task automatic check_idle(input string tag, input logic [1:0] sel_exp);
    check({tag, "_en"},    {28'd0, Shape_En}, 32'd0);
    check({tag, "_sel"},   {30'd0, Sel}, {30'd0, sel_exp});
    check({tag, "_blank"}, {31'd0, Blank}, 32'd0);
    check({tag, "_busy"},  {31'd0, Busy}, 32'd0);
    check({tag, "_pout"},  {31'd0, Pulse_Out}, 32'd0);
  endtask

  task automatic do_reset();
    Reset_N   = 1'b0;
    Enable_SW = 4'b0000;
    Pulse_In  = 4'b0000;
    step();
    step();
    check_idle("rst", 2'd0);
    Reset_N = 1'b1;
  endtask

  // Checks a free-running schedule: grants last 10 cycles (2 guard + 8 run)
  // and cycle through the listed order.
  task automatic run_sched(input string tag, input int ncyc, input int nord, input logic [7:0] order);
    logic [1:0] s;
    logic [7:0] ord;
    ord = order;
    step();
    step();
    check({tag, "_lat2"}, {28'd0, Shape_En}, 32'd0);
    step();
    for (int n = 0; n < ncyc; n++) begin
      s = ord[2*((n/10)%nord) +: 2];
      check({tag, "_sel"},    {30'd0, Sel}, {30'd0, s});
      check({tag, "_en"},     {28'd0, Shape_En}, 32'd1 << s);
      check({tag, "_blank"},  {31'd0, Blank}, ((n % 10) < 2) ? 32'd1 : 32'd0);
      check({tag, "_onehot"}, {31'd0, $onehot0(Shape_En)}, 32'd1);
      step();
    end
    $display("[TB] %s: %0d cycles of schedule checked", tag, ncyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_N   = 1'b0;
    Enable_SW = 4'b0000;
    Pulse_In  = 4'b0000;
    @(negedge sysclk);

    // Single request: latency 3, guard of 2 with pulses masked, then pass-through.
    do_reset();
    Enable_SW = 4'b0001;
    step();
    step();
    check("single_lat2", {28'd0, Shape_En}, 32'd0);
    step();
    for (int n = 0; n < 24; n++) begin
      Pulse_In = 4'($urandom_range(0, 15));
      #1;
      check("single_en",    {28'd0, Shape_En}, 32'd1);
      check("single_blank", {31'd0, Blank}, (n < 2) ? 32'd1 : 32'd0);
      check("single_pout",  {31'd0, Pulse_Out}, (n < 2) ? 32'd0 : {31'd0, Pulse_In[0]});
      check("single_busy",  {31'd0, Busy}, 32'd1);
      step();
    end
    $display("[TB] single: grant 0 held with pass-through");

    // Guard masking with the pulse forced high throughout.
    do_reset();
    Enable_SW = 4'b0001;
    Pulse_In  = 4'b1111;
    step(); step(); step();
    check("guard_pout0", {31'd0, Pulse_Out}, 32'd0);
    step();
    check("guard_pout1", {31'd0, Pulse_Out}, 32'd0);
    step();
    check("guard_pout_run", {31'd0, Pulse_Out}, 32'd1);
    $display("[TB] guard: pulse masked for both guard cycles");

    do_reset();
    Enable_SW = 4'b0101;
    run_sched("alt02", 40, 2, 8'b0000_1000);

    do_reset();
    Enable_SW = 4'b1111;
    run_sched("rr", 50, 4, 8'b1110_0100);

    // Request dropped mid-run ends the dwell 3 edges later.
    do_reset();
    Enable_SW = 4'b0010;
    step(); step(); step();
    check("drop_sel", {30'd0, Sel}, 32'd1);
    for (int n = 0; n < 5; n++) step();
    Enable_SW = 4'b0000;
    step();
    step();
    check("drop_busy_e2", {31'd0, Busy}, 32'd1);
    step();
    check_idle("drop", 2'd1);
    $display("[TB] drop: idle after request release");

    // Reset pulse mid-run, then regrant after a full synchroniser refill.
    do_reset();
    Enable_SW = 4'b0010;
    step(); step(); step();
    for (int n = 0; n < 4; n++) step();
    check("mrst_busy_before", {31'd0, Busy}, 32'd1);
    Reset_N = 1'b0;
    step();
    check_idle("mrst", 2'd0);
    Reset_N = 1'b1;
    step();
    check("mrst_e1_en", {28'd0, Shape_En}, 32'd0);
    step();
    check("mrst_e2_en", {28'd0, Shape_En}, 32'd0);
    step();
    check("mrst_e3_en", {28'd0, Shape_En}, 32'd2);
    check("mrst_e3_blank", {31'd0, Blank}, 32'd1);
    $display("[TB] midreset: regrant to 1 three edges after release");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shape_scheduler.md
SHAPE_SCHEDULER -- requirements
Module: shape_scheduler

Interface
REQ-001 Parameter DWELL_CYCLES, default 50000, SHALL set the sysclk cycles one shape owns the output per grant (1 ms at 50 MHz).
REQ-002 Parameter GUARD_CYCLES, default 4, SHALL set the blanking cycles between enabling a generator and passing its output.
REQ-003 sysclk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset_N  input  1  synchronous, active-low reset, sampled on the rising edge of sysclk.
REQ-005 Enable_SW  input  4  asynchronous switch requests, bit i requests shape generator i, active high.
REQ-006 Pulse_In  input  4  pulse outputs of shape generators 0..3.
REQ-007 Shape_En  output  4  one-hot enable to the granted generator; all zero when none is granted.
REQ-008 Sel  output  2  index of the granted generator.
REQ-009 Pulse_Out  output  1  output of the granted generator, gated by blanking.
REQ-010 Blank  output  1  high during GUARD state.
REQ-011 Busy  output  1  high in any state other than IDLE.

Function
REQ-012 Each Enable_SW bit SHALL pass through a 2-flop synchroniser; only the synchronised value (req) SHALL be used.
REQ-013 The FSM SHALL have exactly three states: IDLE, GUARD, RUN.
REQ-014 In IDLE: Shape_En=0, Blank=0, Busy=0, Pulse_Out=0, Sel holds its last value.
REQ-015 IDLE with any req bit high SHALL go to GUARD on the next edge, granting the winner of the round-robin search.
REQ-016 Round-robin search SHALL start at index (last_grant+1) mod 4 and pick the first index with req high.
REQ-017 On each grant, Sel and last_grant SHALL load the winner, and Shape_En SHALL become the one-hot of the winner in the same cycle.
REQ-018 GUARD SHALL last exactly GUARD_CYCLES cycles with Blank=1, Pulse_Out=0, and the granted Shape_En bit high; the next state is RUN.
REQ-019 RUN SHALL last exactly DWELL_CYCLES cycles with Blank=0 and Pulse_Out=Pulse_In[Sel], combinationally.
REQ-020 At the end of the dwell, if another req bit is high, the FSM SHALL grant the round-robin winner and enter GUARD.
REQ-021 At the end of the dwell, if only the current req bit is high, the FSM SHALL stay in RUN, restart the dwell count, and skip GUARD.
REQ-022 At the end of the dwell, if no req bit is high, the FSM SHALL go to IDLE.
REQ-023 If req[Sel] falls during GUARD or RUN, the dwell SHALL end on the next edge and follow REQ-020..022, excluding index Sel.
REQ-024 A single counter SHALL serve GUARD and RUN, sized for max(DWELL_CYCLES, GUARD_CYCLES), and SHALL clear on every state entry.
REQ-025 The counter SHALL never wrap: terminal count forces a transition.
REQ-026 Shape_En SHALL never have more than one bit set, including on transition cycles.
REQ-027 Latency SHALL be 3 sysclk edges from an Enable_SW rise, with the FSM in IDLE, to Shape_En asserted: 2 synchroniser edges plus 1 FSM edge.

Reset
REQ-028 Reset_N=0 on an edge SHALL set: state=IDLE, Shape_En=0, Sel=0, last_grant=3, counter=0, synchroniser flops=0, Blank=0, Busy=0, Pulse_Out=0.
REQ-029 Reset asserted mid-GUARD or mid-RUN SHALL abort on that edge with no further Shape_En cycles.
REQ-030 After Reset_N returns high, index 0 SHALL have first priority.

Verification (DWELL_CYCLES=8, GUARD_CYCLES=2)
REQ-031 Enable_SW=0001 after reset -> Shape_En=0001 on edge 3; Blank=1 for 2 cycles; then Pulse_Out tracks Pulse_In[0] indefinitely, with no further Blank pulses.
REQ-032 Enable_SW=0101 -> grants alternate 0,2,0,2; each grant = 2 GUARD + 8 RUN cycles; Shape_En is always one-hot or zero.
REQ-033 Enable_SW=1111 from reset -> grant order 0,1,2,3,0.
REQ-034 Grant 1 active, then Enable_SW[1] dropped at RUN count 3 -> RUN exits within 3 edges (2 sync + 1); if no other request, state=IDLE and Shape_En=0.
REQ-035 Reset_N pulsed low for 1 cycle mid-RUN with Enable_SW=0010 -> outputs are at reset values next cycle; regrant to 1 occurs 3 edges after release (synchroniser cleared).
REQ-036 Pulse_In[Sel] toggling during GUARD -> Pulse_Out stays 0 for both GUARD cycles.
